// File: rtl/fetch_unit.sv
// fetch_unit: program counter and instruction-fetch stage of the single-cycle
// RISC core. Sequences the PC from the decoder controls (jmp, halt, rti) and
// owns the single-level interrupt context (saved return PC and saved flags).
//
// Optional build macro: FETCH_IRQ_WAKE_EN
//   When defined, an irq outside interrupt context wakes the core from HALTED
//   and returns to the instruction after the HALT.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   jmp            taken jump/branch this cycle
//   jmp_target     jump destination
//   halt           current instruction is HALT
//   rti            current instruction is return-from-interrupt
//   irq            level interrupt request
//   flags_in       CPU flags, captured on interrupt entry
//   IM_address     current PC, drives instruction memory
//   pc_plus1       IM_address + 1 (combinational, wraps)
//   irq_ack        one-cycle pulse in the cycle after interrupt entry
//   flags_restore  saved flags, valid while restore_flags=1
//   restore_flags  one-cycle pulse in the cycle after a valid rti
//   in_isr         interrupt context active
//   halted         core is in HALTED
//
// state  | meaning
// RUN    | fetching; PC advances every cycle
// HALTED | PC frozen until reset (or irq wake when enabled)

module fetch_unit #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = 16'h0000,
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = 16'h0010
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              halt,
  input  logic              rti,
  input  logic              irq,
  input  logic [3:0]        flags_in,
  output logic [ADDR_W-1:0] IM_address,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              irq_ack,
  output logic [3:0]        flags_restore,
  output logic              restore_flags,
  output logic              in_isr,
  output logic              halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [3:0]        saved_flags_q, saved_flags_d;
  logic              in_isr_q, in_isr_d;
  logic              irq_ack_q, irq_ack_d;
  logic              restore_flags_q, restore_flags_d;
  logic [3:0]        flags_restore_q, flags_restore_d;
  logic [ADDR_W-1:0] npc;
  logic              valid_rti;

  assign pc_plus1 = pc_q + PC_ONE;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    epc_d           = epc_q;
    saved_flags_d   = saved_flags_q;
    in_isr_d        = in_isr_q;
    irq_ack_d       = 1'b0;
    restore_flags_d = 1'b0;
    flags_restore_d = flags_restore_q;
    npc             = pc_plus1;
    valid_rti       = 1'b0;

    case (state_q)
      RUN: begin
        if (halt) begin
          npc     = pc_q;
          state_d = HALTED;
        end else if (rti && in_isr_q) begin
          valid_rti       = 1'b1;
          npc             = epc_q;
          in_isr_d        = 1'b0;
          restore_flags_d = 1'b1;
          flags_restore_d = saved_flags_q;
        end else if (rti) begin
          // rti outside an ISR behaves as a NOP, even over a jmp
          npc = pc_plus1;
        end else if (jmp) begin
          npc = jmp_target;
        end
        pc_d = npc;

        // Entry saves the already-resolved next PC so a jump target survives
        if (irq && !in_isr_q && !halt && !valid_rti) begin
          epc_d         = npc;
          saved_flags_d = flags_in;
          pc_d          = IRQ_VEC;
          in_isr_d      = 1'b1;
          irq_ack_d     = 1'b1;
        end
      end

      HALTED: begin
`ifdef FETCH_IRQ_WAKE_EN
        if (irq && !in_isr_q) begin
          epc_d         = pc_plus1;
          saved_flags_d = flags_in;
          pc_d          = IRQ_VEC;
          in_isr_d      = 1'b1;
          irq_ack_d     = 1'b1;
          state_d       = RUN;
        end
`else
        state_d = HALTED;
`endif
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      pc_q            <= RESET_VEC;
      epc_q           <= '0;
      saved_flags_q   <= 4'b0;
      in_isr_q        <= 1'b0;
      irq_ack_q       <= 1'b0;
      restore_flags_q <= 1'b0;
      flags_restore_q <= 4'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      epc_q           <= epc_d;
      saved_flags_q   <= saved_flags_d;
      in_isr_q        <= in_isr_d;
      irq_ack_q       <= irq_ack_d;
      restore_flags_q <= restore_flags_d;
      flags_restore_q <= flags_restore_d;
    end
  end

  assign IM_address    = pc_q;
  assign irq_ack       = irq_ack_q;
  assign flags_restore = flags_restore_q;
  assign restore_flags = restore_flags_q;
  assign in_isr        = in_isr_q;
  assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        halt;
  logic        rti;
  logic        irq;
  logic [3:0]  flags_in;
  logic [15:0] IM_address;
  logic [15:0] pc_plus1;
  logic        irq_ack;
  logic [3:0]  flags_restore;
  logic        restore_flags;
  logic        in_isr;
  logic        halted;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .jmp(jmp), .jmp_target(jmp_target),
    .halt(halt), .rti(rti), .irq(irq), .flags_in(flags_in),
    .IM_address(IM_address), .pc_plus1(pc_plus1), .irq_ack(irq_ack),
    .flags_restore(flags_restore), .restore_flags(restore_flags),
    .in_isr(in_isr), .halted(halted)
  );

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [15:0] tgt;
    logic        halt;
    logic        rti;
    logic        irq;
    logic [3:0]  flags;
    logic [15:0] e_pc;
    logic        e_ack;
    logic        e_rstf;
    logic [3:0]  e_fr;
    logic        e_isr;
    logic        e_halt;
    logic        chk_fr;
  } vec_t;

  function automatic vec_t mk(logic r, logic j, logic [15:0] t, logic h,
                              logic ri, logic iq, logic [3:0] f,
                              logic [15:0] pc, logic ack, logic rf,
                              logic [3:0] fr, logic isr, logic hl, logic cf);
    vec_t v;
    v.rst = r; v.jmp = j; v.tgt = t; v.halt = h; v.rti = ri; v.irq = iq;
    v.flags = f; v.e_pc = pc; v.e_ack = ack; v.e_rstf = rf; v.e_fr = fr;
    v.e_isr = isr; v.e_halt = hl; v.chk_fr = cf;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp, int idx);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    logic [15:0] e_p1;
    reset = v.rst; jmp = v.jmp; jmp_target = v.tgt; halt = v.halt;
    rti = v.rti; irq = v.irq; flags_in = v.flags;
    @(posedge clk);
    #1;
    n_vec++;
    e_p1 = v.e_pc + 16'd1;
    chk("IM_address", IM_address, v.e_pc, idx);
    chk("pc_plus1", pc_plus1, e_p1, idx);
    chk("irq_ack", {15'd0, irq_ack}, {15'd0, v.e_ack}, idx);
    chk("restore_flags", {15'd0, restore_flags}, {15'd0, v.e_rstf}, idx);
    chk("in_isr", {15'd0, in_isr}, {15'd0, v.e_isr}, idx);
    chk("halted", {15'd0, halted}, {15'd0, v.e_halt}, idx);
    if (v.chk_fr)
      chk("flags_restore", {12'd0, flags_restore}, {12'd0, v.e_fr}, idx);
  endtask

  vec_t tbl[19];
  int   k;

  initial begin
    reset = 1'b1; jmp = 1'b0; jmp_target = 16'h0; halt = 1'b0;
    rti = 1'b0; irq = 1'b0; flags_in = 4'h0;

    //            rst jmp tgt      hlt rti irq flg      pc       ack rf fr       isr hlt cfr
    tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0, 1);
    tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0001, 0, 0, 4'b0000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0002, 0, 0, 4'b0000, 0, 0, 0);
    tbl[3]  = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0003, 0, 0, 4'b0000, 0, 0, 0);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'h0004, 0, 0, 4'b0000, 0, 0, 0);
    tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0005, 0, 0, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(0, 1, 16'h0040, 0, 0, 0, 4'b0000, 16'h0040, 0, 0, 4'b0000, 0, 0, 0);
    tbl[7]  = mk(0, 1, 16'hFFFF, 0, 0, 0, 4'b0000, 16'hFFFF, 0, 0, 4'b0000, 0, 0, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0, 0);
    tbl[9]  = mk(0, 1, 16'h0007, 0, 0, 0, 4'b0000, 16'h0007, 0, 0, 4'b0000, 0, 0, 0);
    tbl[10] = mk(0, 1, 16'h0020, 0, 0, 1, 4'b1010, 16'h0010, 1, 0, 4'b0000, 1, 0, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0, 1, 4'b0000, 16'h0011, 0, 0, 4'b0000, 1, 0, 0);
    tbl[12] = mk(0, 1, 16'h0080, 0, 0, 1, 4'b0000, 16'h0080, 0, 0, 4'b0000, 1, 0, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 1, 1, 4'b0000, 16'h0020, 0, 1, 4'b1010, 0, 0, 1);
    tbl[14] = mk(0, 0, 16'h0000, 0, 0, 1, 4'b0101, 16'h0010, 1, 0, 4'b0000, 1, 0, 0);
    tbl[15] = mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0011, 0, 0, 4'b0000, 1, 0, 0);
    tbl[16] = mk(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'h0021, 0, 1, 4'b0101, 0, 0, 1);
    tbl[17] = mk(0, 1, 16'h0009, 0, 0, 0, 4'b0000, 16'h0009, 0, 0, 4'b0000, 0, 0, 0);
    tbl[18] = mk(0, 0, 16'h0000, 1, 0, 1, 4'b1111, 16'h0009, 0, 0, 4'b0000, 0, 1, 0);

    for (int i = 0; i < 19; i++) step(tbl[i], i);
    k = 100;

`ifdef FETCH_IRQ_WAKE_EN
    // Wake from HALTED, then rti returns to the instruction after HALT
    step(mk(0, 0, 16'h0000, 0, 0, 1, 4'b0011, 16'h0010, 1, 0, 4'b0000, 1, 0, 0), k++);
    step(mk(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'h000A, 0, 1, 4'b0011, 0, 0, 1), k++);
`else
    // HALTED ignores everything but reset
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, 16'h0055, 1, 1, 1, 4'b0011, 16'h0009, 0, 0, 4'b0000, 0, 1, 0), k++);
`endif

    // Reset out of HALTED / any state, then RUN resumes
    step(mk(1, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0, 1), k++);
    step(mk(0, 0, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 1, 0), k++);
    step(mk(1, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000, 0, 0, 1), k++);
    step(mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0001, 0, 0, 4'b0000, 0, 0, 0), k++);

    // Reset mid-ISR at PC=0x0012 with irq and rti asserted
    step(mk(0, 0, 16'h0000, 0, 0, 1, 4'b0110, 16'h0010, 1, 0, 4'b0000, 1, 0, 0), k++);
    step(mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0011, 0, 0, 4'b0000, 1, 0, 0), k++);
    step(mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0012, 0, 0, 4'b0000, 1, 0, 0), k++);
    step(mk(1, 1, 16'h0033, 1, 1, 1, 4'b1111, 16'h0000, 0, 0, 4'b0000, 0, 0, 1), k++);
    // in_isr really cleared: rti is now a NOP
    step(mk(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'h0001, 0, 0, 4'b0000, 0, 0, 0), k++);

    // EPC captures the wrapped 0x0000
    step(mk(0, 1, 16'hFFFF, 0, 0, 0, 4'b0000, 16'hFFFF, 0, 0, 4'b0000, 0, 0, 0), k++);
    step(mk(0, 0, 16'h0000, 0, 0, 1, 4'b1100, 16'h0010, 1, 0, 4'b0000, 1, 0, 0), k++);
    step(mk(0, 0, 16'h0000, 0, 1, 0, 4'b0000, 16'h0000, 0, 1, 4'b1100, 0, 0, 1), k++);
    step(mk(0, 0, 16'h0000, 0, 0, 0, 4'b0000, 16'h0001, 0, 0, 4'b0000, 0, 0, 0), k++);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
